// File: rtl/instruction_decode_hz.sv
// MIPS ID stage: register file, control decode and ID/EX register, with
// load-use and branch hazard detection, MEM-to-ID branch forwarding and a sticky halt.
module instruction_decode_hz #(
  parameter int NB_DATA    = 32,
  parameter int NB_ADDR    = 5,
  parameter int BRANCH_FWD = 1
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_valid,
  input  logic [NB_DATA-1:0] i_pc4,
  input  logic [31:0]        i_instruction,
  input  logic               i_halt,
  input  logic               i_wb_write,
  input  logic [NB_ADDR-1:0] i_wb_addr,
  input  logic [NB_DATA-1:0] i_wb_data,
  input  logic               i_mem_wb_write,
  input  logic               i_mem_read,
  input  logic [NB_ADDR-1:0] i_mem_dst,
  input  logic [NB_DATA-1:0] i_mem_alu,
  output logic               o_stall,
  output logic               o_flush,
  output logic               o_jump,
  output logic [NB_DATA-1:0] o_jump_addr,
  output logic               o_halt,
  output logic               o_valid,
  output logic [NB_DATA-1:0] o_RA,
  output logic [NB_DATA-1:0] o_RB,
  output logic [NB_ADDR-1:0] o_rs,
  output logic [NB_ADDR-1:0] o_rt,
  output logic [NB_ADDR-1:0] o_dst,
  output logic [5:0]         o_opcode,
  output logic [5:0]         o_funct,
  output logic [4:0]         o_shamt,
  output logic [NB_DATA-1:0] o_imm,
  output logic               o_wb_write,
  output logic               o_wb_mem_to_reg,
  output logic               o_mem_read,
  output logic               o_mem_write,
  output logic               o_mem_unsigned,
  output logic               o_alu_src,
  output logic [1:0]         o_mem_size,
  output logic [1:0]         o_alu_op,
  input  logic [NB_ADDR-1:0] i_dbg_addr,
  output logic [NB_DATA-1:0] o_dbg_data
);

  localparam int NREG = 2 ** NB_ADDR;
  localparam logic [NB_ADDR-1:0] ZERO_ADDR = NB_ADDR'(0);

  logic [NB_DATA-1:0] regs [NREG];

  logic               frozen, rf_we;
  logic [5:0]         op, funct;
  logic [4:0]         shamt;
  logic [NB_ADDR-1:0] rs, rt, rd, addr_a;
  logic [NB_DATA-1:0] imm, rdata_a, rdata_b, fwd_a, fwd_b, op_a, op_b, br_target, target;
  logic               is_rtype, is_jr, is_jalr, is_j, is_jal, is_beq, is_bne;
  logic               is_load, is_store, is_immop, is_nop, is_halt_instr, is_br, is_link;
  logic               use_rs, use_rt, ex_hit, mem_hit, load_use, br_ex, br_mem, take, issue;
  logic [NB_ADDR-1:0] dst;
  logic               wb, m2r, mrd, mwr, mun, alu_src;
  logic [1:0]         msz, alu_op;

  function automatic logic src_hit(input logic [NB_ADDR-1:0] d, input logic [NB_ADDR-1:0] a,
                                   input logic [NB_ADDR-1:0] b, input logic ua, input logic ub);
    return (d != ZERO_ADDR) && ((ua && (d == a)) || (ub && (d == b)));
  endfunction

  assign frozen = i_halt | o_halt;
  // r0 is never written, so the array reset value keeps it reading zero
  assign rf_we  = i_wb_write & ~frozen & (i_wb_addr != ZERO_ADDR);

  assign op     = i_instruction[31:26];
  assign rs     = NB_ADDR'(i_instruction[25:21]);
  assign rt     = NB_ADDR'(i_instruction[20:16]);
  assign rd     = NB_ADDR'(i_instruction[15:11]);
  assign shamt  = i_instruction[10:6];
  assign funct  = i_instruction[5:0];
  assign imm    = {{(NB_DATA-16){i_instruction[15]}}, i_instruction[15:0]};

  assign is_rtype      = (op == 6'h00);
  assign is_jr         = is_rtype & (funct == 6'h08);
  assign is_jalr       = is_rtype & (funct == 6'h09);
  assign is_j          = (op == 6'h02);
  assign is_jal        = (op == 6'h03);
  assign is_beq        = (op == 6'h04);
  assign is_bne        = (op == 6'h05);
  assign is_load       = op[5] & ~op[3];
  assign is_store      = op[5] & op[3];
  assign is_immop      = (op[5:3] == 3'b001);
  assign is_nop        = (i_instruction == 32'h0000_0000);
  assign is_halt_instr = (i_instruction == 32'hFFFF_FFFF);
  assign is_br         = is_beq | is_bne | is_jr | is_jalr;
  assign is_link       = is_jal | is_jalr;
  assign use_rs        = ~(is_j | is_jal);
  assign use_rt        = is_rtype | is_store | is_beq | is_bne;

  // While frozen, port A serves the debug unit
  assign addr_a     = frozen ? i_dbg_addr : rs;
  assign rdata_a    = (rf_we && (i_wb_addr == addr_a)) ? i_wb_data : regs[addr_a];
  assign rdata_b    = (rf_we && (i_wb_addr == rt)) ? i_wb_data : regs[rt];
  assign o_dbg_data = rdata_a;

  // Register file with synchronous clear
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= {NB_DATA{1'b0}};
    end else if (rf_we) begin
      regs[i_wb_addr] <= i_wb_data;
    end
  end

  // Control decode
  always_comb begin
    dst     = ZERO_ADDR;
    wb      = 1'b0;
    m2r     = 1'b0;
    mrd     = 1'b0;
    mwr     = 1'b0;
    mun     = 1'b0;
    msz     = 2'b00;
    alu_op  = 2'b01;
    alu_src = 1'b0;
    if (is_rtype) begin
      dst = rd;
      wb  = 1'b1;
      m2r = 1'b1;
      case (funct)
        6'h08:   begin dst = ZERO_ADDR; wb = 1'b0; alu_op = 2'b10; end
        6'h09:   alu_op = 2'b00;
        default: alu_op = 2'b10;
      endcase
    end else if (is_jal) begin
      dst    = NB_ADDR'(31);
      wb     = 1'b1;
      m2r    = 1'b1;
      alu_op = 2'b00;
    end else if (op[5]) begin
      mun     = op[2];
      msz     = op[1:0];
      alu_op  = 2'b00;
      alu_src = 1'b1;
      if (is_load) begin
        dst = rt;
        wb  = 1'b1;
        mrd = 1'b1;
      end else begin
        mwr = 1'b1;
      end
    end else if (is_immop) begin
      dst     = rt;
      wb      = 1'b1;
      m2r     = 1'b1;
      alu_op  = 2'b11;
      alu_src = 1'b1;
    end else begin
      alu_op = 2'b01;
    end
  end

  assign op_a = is_link ? i_pc4 : rdata_a;
  assign op_b = is_link ? NB_DATA'(4) : rdata_b;

  // A non-load result in EX/MEM may feed the comparator directly
  assign fwd_a = ((BRANCH_FWD != 0) && i_mem_wb_write && !i_mem_read &&
                  (i_mem_dst != ZERO_ADDR) && (i_mem_dst == rs)) ? i_mem_alu : rdata_a;
  assign fwd_b = ((BRANCH_FWD != 0) && i_mem_wb_write && !i_mem_read &&
                  (i_mem_dst != ZERO_ADDR) && (i_mem_dst == rt)) ? i_mem_alu : rdata_b;

  assign ex_hit   = src_hit(o_dst, rs, rt, use_rs, use_rt);
  assign mem_hit  = i_mem_wb_write & src_hit(i_mem_dst, rs, rt, use_rs, use_rt);
  assign load_use = o_valid & o_mem_read & ex_hit;
  assign br_ex    = is_br & o_valid & o_wb_write & ex_hit;
  assign br_mem   = is_br & mem_hit & (i_mem_read | (BRANCH_FWD == 0));
  assign o_stall  = i_valid & ~frozen & (load_use | br_ex | br_mem);

  assign br_target = i_pc4 + {imm[NB_DATA-3:0], 2'b00};

  // Jump condition and redirect target
  always_comb begin
    take   = 1'b0;
    target = br_target;
    if (is_beq) begin
      take = (fwd_a == fwd_b);
    end else if (is_bne) begin
      take = (fwd_a != fwd_b);
    end else if (is_j | is_jal) begin
      take   = 1'b1;
      target = {i_pc4[NB_DATA-1:28], i_instruction[25:0], 2'b00};
    end else if (is_jr | is_jalr) begin
      take   = 1'b1;
      target = fwd_a;
    end else begin
      take = 1'b0;
    end
  end

  assign o_jump      = i_valid & ~o_stall & ~frozen & take;
  assign o_flush     = o_jump;
  assign o_jump_addr = target;
  assign issue       = i_valid & ~o_stall & ~is_nop & ~is_halt_instr;

  // ID/EX register and sticky halt; frozen cycles hold everything
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_halt <= 1'b0; o_valid <= 1'b0;
      o_RA <= {NB_DATA{1'b0}}; o_RB <= {NB_DATA{1'b0}}; o_imm <= {NB_DATA{1'b0}};
      o_rs <= ZERO_ADDR; o_rt <= ZERO_ADDR; o_dst <= ZERO_ADDR;
      o_opcode <= 6'h00; o_funct <= 6'h00; o_shamt <= 5'h00;
      o_wb_write <= 1'b0; o_wb_mem_to_reg <= 1'b0; o_mem_read <= 1'b0; o_mem_write <= 1'b0;
      o_mem_unsigned <= 1'b0; o_alu_src <= 1'b0; o_mem_size <= 2'b00; o_alu_op <= 2'b00;
    end else if (!frozen) begin
      if (i_valid && !o_stall && is_halt_instr) o_halt <= 1'b1;
      if (issue) begin
        o_valid <= 1'b1;
        o_RA <= op_a; o_RB <= op_b; o_imm <= imm;
        o_rs <= is_link ? ZERO_ADDR : rs; o_rt <= rt; o_dst <= dst;
        o_opcode <= op; o_funct <= funct; o_shamt <= shamt;
        o_wb_write <= wb; o_wb_mem_to_reg <= m2r; o_mem_read <= mrd; o_mem_write <= mwr;
        o_mem_unsigned <= mun; o_alu_src <= alu_src; o_mem_size <= msz; o_alu_op <= alu_op;
      end else begin
        o_valid <= 1'b0;
        o_RA <= {NB_DATA{1'b0}}; o_RB <= {NB_DATA{1'b0}}; o_imm <= {NB_DATA{1'b0}};
        o_rs <= ZERO_ADDR; o_rt <= ZERO_ADDR; o_dst <= ZERO_ADDR;
        o_opcode <= 6'h00; o_funct <= 6'h00; o_shamt <= 5'h00;
        o_wb_write <= 1'b0; o_wb_mem_to_reg <= 1'b0; o_mem_read <= 1'b0; o_mem_write <= 1'b0;
        o_mem_unsigned <= 1'b0; o_alu_src <= 1'b0; o_mem_size <= 2'b00; o_alu_op <= 2'b00;
      end
    end
  end

endmodule

// File: tb/tb_instruction_decode_hz.sv
// Scoreboard bench for instruction_decode_hz: directed cycles push expectations,
// a negedge monitor pops and compares. A BRANCH_FWD=0 copy shares the inputs.
module tb_instruction_decode_hz;

  logic        i_clk = 1'b0;
  logic        i_reset, i_valid, i_halt, i_wb_write, i_mem_wb_write, i_mem_read;
  logic [31:0] i_pc4, i_instruction, i_wb_data, i_mem_alu;
  logic [4:0]  i_wb_addr, i_mem_dst, i_dbg_addr;

  logic        o_stall, o_flush, o_jump, o_halt, o_valid;
  logic [31:0] o_jump_addr, o_RA, o_RB, o_imm, o_dbg_data;
  logic [4:0]  o_rs, o_rt, o_dst, o_shamt;
  logic [5:0]  o_opcode, o_funct;
  logic        o_wb_write, o_wb_mem_to_reg, o_mem_read, o_mem_write, o_mem_unsigned, o_alu_src;
  logic [1:0]  o_mem_size, o_alu_op;

  logic        z_stall, z_flush, z_jump, z_halt, z_valid;
  logic [31:0] z_jump_addr, z_RA, z_RB, z_imm, z_dbg_data;
  logic [4:0]  z_rs, z_rt, z_dst, z_shamt;
  logic [5:0]  z_opcode, z_funct;
  logic        z_wb_write, z_wb_mem_to_reg, z_mem_read, z_mem_write, z_mem_unsigned, z_alu_src;
  logic [1:0]  z_mem_size, z_alu_op;

  always #5 i_clk = ~i_clk;

  instruction_decode_hz dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .i_pc4(i_pc4),
    .i_instruction(i_instruction), .i_halt(i_halt), .i_wb_write(i_wb_write),
    .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data), .i_mem_wb_write(i_mem_wb_write),
    .i_mem_read(i_mem_read), .i_mem_dst(i_mem_dst), .i_mem_alu(i_mem_alu),
    .o_stall(o_stall), .o_flush(o_flush), .o_jump(o_jump), .o_jump_addr(o_jump_addr),
    .o_halt(o_halt), .o_valid(o_valid), .o_RA(o_RA), .o_RB(o_RB), .o_rs(o_rs), .o_rt(o_rt),
    .o_dst(o_dst), .o_opcode(o_opcode), .o_funct(o_funct), .o_shamt(o_shamt), .o_imm(o_imm),
    .o_wb_write(o_wb_write), .o_wb_mem_to_reg(o_wb_mem_to_reg), .o_mem_read(o_mem_read),
    .o_mem_write(o_mem_write), .o_mem_unsigned(o_mem_unsigned), .o_alu_src(o_alu_src),
    .o_mem_size(o_mem_size), .o_alu_op(o_alu_op), .i_dbg_addr(i_dbg_addr), .o_dbg_data(o_dbg_data)
  );

  instruction_decode_hz #(.BRANCH_FWD(0)) dut0 (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .i_pc4(i_pc4),
    .i_instruction(i_instruction), .i_halt(i_halt), .i_wb_write(i_wb_write),
    .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data), .i_mem_wb_write(i_mem_wb_write),
    .i_mem_read(i_mem_read), .i_mem_dst(i_mem_dst), .i_mem_alu(i_mem_alu),
    .o_stall(z_stall), .o_flush(z_flush), .o_jump(z_jump), .o_jump_addr(z_jump_addr),
    .o_halt(z_halt), .o_valid(z_valid), .o_RA(z_RA), .o_RB(z_RB), .o_rs(z_rs), .o_rt(z_rt),
    .o_dst(z_dst), .o_opcode(z_opcode), .o_funct(z_funct), .o_shamt(z_shamt), .o_imm(z_imm),
    .o_wb_write(z_wb_write), .o_wb_mem_to_reg(z_wb_mem_to_reg), .o_mem_read(z_mem_read),
    .o_mem_write(z_mem_write), .o_mem_unsigned(z_mem_unsigned), .o_alu_src(z_alu_src),
    .o_mem_size(z_mem_size), .o_alu_op(z_alu_op), .i_dbg_addr(i_dbg_addr), .o_dbg_data(z_dbg_data)
  );

  typedef struct {
    bit cc; logic stall, jump;
    bit ca; logic [31:0] jaddr;
    bit cr; logic valid; logic [4:0] dst, rs; logic [31:0] ra, rb; logic wb, mrd; logic [1:0] alu;
    bit ch; logic halt;
    bit cd; logic [31:0] dbg;
    bit c0; logic stall0, jump0;
  } exp_t;

  exp_t e, m;
  exp_t q[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one expectation per driven cycle, compared mid-cycle
  always @(negedge i_clk) begin
    if (q.size() > 0) begin
      m = q.pop_front();
      if (m.cc) begin
        chk("stall", 32'(o_stall), 32'(m.stall));
        chk("jump", 32'(o_jump), 32'(m.jump));
        chk("flush", 32'(o_flush), 32'(m.jump));
      end
      if (m.ca) chk("jump_addr", o_jump_addr, m.jaddr);
      if (m.cr) begin
        chk("valid", 32'(o_valid), 32'(m.valid));
        chk("dst", 32'(o_dst), 32'(m.dst));
        chk("rs", 32'(o_rs), 32'(m.rs));
        chk("RA", o_RA, m.ra);
        chk("RB", o_RB, m.rb);
        chk("wb_write", 32'(o_wb_write), 32'(m.wb));
        chk("mem_read", 32'(o_mem_read), 32'(m.mrd));
        chk("alu_op", 32'(o_alu_op), 32'(m.alu));
      end
      if (m.ch) chk("halt", 32'(o_halt), 32'(m.halt));
      if (m.cd) chk("dbg_data", o_dbg_data, m.dbg);
      if (m.c0) begin
        chk("nofwd_stall", 32'(z_stall), 32'(m.stall0));
        chk("nofwd_jump", 32'(z_jump), 32'(m.jump0));
      end
    end
  end

  task automatic idle();
    i_valid = 1'b0; i_pc4 = 32'h0; i_instruction = 32'h0; i_halt = 1'b0;
    i_wb_write = 1'b0; i_wb_addr = 5'd0; i_wb_data = 32'h0;
    i_mem_wb_write = 1'b0; i_mem_read = 1'b0; i_mem_dst = 5'd0; i_mem_alu = 32'h0;
    i_dbg_addr = 5'd0;
  endtask

  task automatic instr(input logic [31:0] ins, input logic [31:0] pc4);
    i_valid = 1'b1; i_instruction = ins; i_pc4 = pc4;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    i_wb_write = 1'b1; i_wb_addr = a; i_wb_data = d;
  endtask

  task automatic expc(input logic s, input logic j);
    e.cc = 1'b1; e.stall = s; e.jump = j;
  endtask

  task automatic expa(input logic [31:0] a);
    e.ca = 1'b1; e.jaddr = a;
  endtask

  task automatic expr(input logic v, input logic [4:0] d, input logic [4:0] s, input logic [31:0] ra,
                      input logic [31:0] rb, input logic w, input logic mr, input logic [1:0] al);
    e.cr = 1'b1; e.valid = v; e.dst = d; e.rs = s; e.ra = ra; e.rb = rb; e.wb = w; e.mrd = mr; e.alu = al;
  endtask

  task automatic exph(input logic h);
    e.ch = 1'b1; e.halt = h;
  endtask

  task automatic expd(input logic [31:0] d);
    e.cd = 1'b1; e.dbg = d;
  endtask

  task automatic exp0(input logic s, input logic j);
    e.c0 = 1'b1; e.stall0 = s; e.jump0 = j;
  endtask

  task automatic step();
    q.push_back(e);
    e = '{default: '0};
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    e = '{default: '0};
    idle();
    i_reset = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    i_reset = 1'b0;

    // reset state, preload r1/r4/r6
    idle(); wb(5'd1, 32'h100); expr(0, 0, 0, 0, 0, 0, 0, 2'b00); expc(0, 0); exph(0); step();
    idle(); wb(5'd4, 32'h55); step();
    idle(); wb(5'd6, 32'h7); step();

    // load-use: lw r2,0(r1) ; add r3,r2,r4
    idle(); instr(32'h8C22_0000, 32'h10); expc(0, 0); step();
    idle(); instr(32'h0044_1820, 32'h14); expc(1, 0); expr(1, 2, 1, 32'h100, 0, 1, 1, 2'b00); step();
    idle(); instr(32'h0044_1820, 32'h14); expc(0, 0); expr(0, 0, 0, 0, 0, 0, 0, 2'b00); step();
    idle(); expc(0, 0); expr(1, 3, 2, 0, 32'h55, 1, 0, 2'b10); step();

    // beq r5,r6,+3 with r5 in EX/MEM (forwarded) vs stalled copy
    idle(); instr(32'h10A6_0003, 32'h100); i_mem_wb_write = 1'b1; i_mem_dst = 5'd5; i_mem_alu = 32'h7;
    expc(0, 1); expa(32'h10C); exp0(1, 0); step();
    idle(); instr(32'h10A6_0003, 32'h100); wb(5'd5, 32'h7); expc(0, 1); expa(32'h10C); exp0(0, 1); step();

    // bypass and r0
    idle(); instr(32'h0120_1820, 32'h104); wb(5'd9, 32'hDEAD_BEEF); expc(0, 0); expr(1, 0, 5, 32'h7, 32'h7, 0, 0, 2'b01); step();
    idle(); instr(32'h0000_1820, 32'h108); wb(5'd0, 32'h5); expr(1, 3, 9, 32'hDEAD_BEEF, 0, 1, 0, 2'b10); step();
    idle(); instr(32'h0000_1820, 32'h10C); expr(1, 3, 0, 0, 0, 1, 0, 2'b10); step();
    idle(); instr(32'h2027_FFFC, 32'h110); expr(1, 3, 0, 0, 0, 1, 0, 2'b10); step();
    idle(); instr(32'hAC22_0008, 32'h114); expr(1, 7, 1, 32'h100, 0, 1, 0, 2'b11); step();

    // bne backward, j with upper PC bits, jal
    idle(); instr(32'h1420_FFFF, 32'h200); expc(0, 1); expa(32'h1FC); expr(1, 0, 1, 32'h100, 0, 0, 0, 2'b00); step();
    idle(); instr(32'h0BFF_FFFF, 32'hA000_0010); expc(0, 1); expa(32'hAFFF_FFFC); expr(1, 0, 1, 32'h100, 0, 0, 0, 2'b01); step();
    idle(); instr(32'h0C00_0010, 32'h40); expc(0, 1); expa(32'h40); expr(1, 0, 31, 0, 0, 0, 0, 2'b01); step();
    idle(); expr(1, 31, 0, 32'h40, 32'h4, 1, 0, 2'b00); step();

    // lw r4 then jr r4: stall in ID/EX, stall in EX/MEM, then jump
    idle(); instr(32'h8C24_0000, 32'h300); expc(0, 0); step();
    idle(); instr(32'h0080_0008, 32'h304); expc(1, 0); expr(1, 4, 1, 32'h100, 32'h55, 1, 1, 2'b00); step();
    idle(); instr(32'h0080_0008, 32'h304); i_mem_wb_write = 1'b1; i_mem_read = 1'b1; i_mem_dst = 5'd4; i_mem_alu = 32'h999;
    expc(1, 0); expr(0, 0, 0, 0, 0, 0, 0, 2'b00); step();
    idle(); instr(32'h0080_0008, 32'h304); wb(5'd4, 32'h1234); expc(0, 1); expa(32'h1234); expr(0, 0, 0, 0, 0, 0, 0, 2'b00); step();
    idle(); expr(1, 0, 4, 32'h1234, 0, 0, 0, 2'b10); step();

    // halt instruction, blocked WB, debug read, hold
    idle(); instr(32'hFFFF_FFFF, 32'h400); expc(0, 0); exph(0); step();
    idle(); wb(5'd9, 32'h1111_1111); i_dbg_addr = 5'd9; exph(1); expr(0, 0, 0, 0, 0, 0, 0, 2'b00); step();
    idle(); instr(32'h0C00_0010, 32'h40); i_dbg_addr = 5'd9; expc(0, 0); exph(1); expd(32'hDEAD_BEEF); step();
    idle(); i_dbg_addr = 5'd9; exph(1); expd(32'hDEAD_BEEF); expr(0, 0, 0, 0, 0, 0, 0, 2'b00); step();

    // reset clears halt and the register file
    idle(); i_reset = 1'b1; step();
    i_reset = 1'b0;
    idle(); instr(32'h0120_1820, 32'h10); exph(0); expr(0, 0, 0, 0, 0, 0, 0, 2'b00); step();

    // external halt freezes ID/EX and suppresses jumps
    idle(); i_halt = 1'b1; expr(1, 3, 9, 0, 0, 1, 0, 2'b10); step();
    idle(); i_halt = 1'b1; instr(32'h0C00_0010, 32'h40); expc(0, 0); expr(1, 3, 9, 0, 0, 1, 0, 2'b10); step();
    idle(); step();

    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
